// File: rtl/act_dispatch.sv
// Routes activation beats into per-row FWFT FIFOs feeding the superblock rows; 1-cycle in->vld latency.
// Backpressure: in_rdy drops only when the addressed row is full or flush is high; other rows keep flowing.

module act_row_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (!push_ok && pop_ok)
                count <= count - 1'b1;
        end
    end

    // Storage is deliberately unreset; head is only meaningful while !empty.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

module act_dispatch #(
    parameter int N_ROW      = 6,
    parameter int WID_ACT    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_ROW    = $clog2(N_ROW)
) (
    input  logic                       clk_l,
    input  logic                       rst_n,
    input  logic [2*WID_ACT-1:0]       in_data,
    input  logic [WID_ROW-1:0]         in_row,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic                       flush,
    output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
    output logic [N_ROW-1:0]           act_data_in_vld,
    input  logic [N_ROW-1:0]           act_data_in_req,
    output logic [N_ROW-1:0]           row_empty,
    output logic                       err_row
);
    localparam int BW = 2 * WID_ACT;

    logic [N_ROW-1:0] full;
    logic [N_ROW-1:0] empty;
    logic             row_ok;
    logic             sel_full;
    logic             accept;

    assign row_ok = 32'(in_row) < N_ROW;

    always_comb begin
        sel_full = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            if (32'(in_row) == r) sel_full = full[r];
        end
    end

    // Out-of-range rows are always accepted so they can be dropped and flagged.
    assign in_rdy = !flush && (!row_ok || !sel_full);
    assign accept = in_vld && in_rdy;

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        logic push_r;
        assign push_r = accept && row_ok && (32'(in_row) == r);

        act_row_fifo #(.W(BW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk_l),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push_r),
            .push_data (in_data),
            .pop       (act_data_in_req[r]),
            .head      (act_data_in[r*BW +: BW]),
            .full      (full[r]),
            .empty     (empty[r])
        );

        assign act_data_in_vld[r] = !empty[r];
        assign row_empty[r]       = empty[r];
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n)
            err_row <= 1'b0;
        else if (accept && !row_ok)
            err_row <= 1'b1;
    end
endmodule

// File: tb/tb_act_dispatch.sv
// Directed bench for act_dispatch: per-row expected queues drained by a negedge monitor.
module tb_act_dispatch;
    localparam int N_ROW = 6;

    logic          clk_l = 1'b0;
    logic          rst_n;
    logic [31:0]   in_data;
    logic [2:0]    in_row;
    logic          in_vld;
    logic          in_rdy;
    logic          flush;
    logic [191:0]  act_data_in;
    logic [5:0]    act_data_in_vld;
    logic [5:0]    act_data_in_req;
    logic [5:0]    row_empty;
    logic          err_row;

    int vectors = 0;
    int errors  = 0;
    logic [31:0] expq [N_ROW][$];

    act_dispatch dut (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_row          (in_row),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .flush           (flush),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .row_empty       (row_empty),
        .err_row         (err_row)
    );

    always #5 clk_l = ~clk_l;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_l);
        #1;
    endtask

    task automatic clear_model();
        for (int r = 0; r < N_ROW; r++) expq[r].delete();
    endtask

    // Called at posedge+1; presents one beat for a single edge.
    task automatic drive(input int row, input logic [31:0] d, input logic exp_rdy);
        in_vld  = 1'b1;
        in_row  = 3'(row);
        in_data = d;
        @(negedge clk_l);
        chk("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
        @(posedge clk_l);
        #1;
        if (exp_rdy && row < N_ROW) expq[row].push_back(d);
        in_vld = 1'b0;
    endtask

    always @(negedge clk_l) begin
        if (rst_n) begin
            for (int r = 0; r < N_ROW; r++) begin
                chk($sformatf("vld[%0d]", r), {31'd0, act_data_in_vld[r]},
                    {31'd0, expq[r].size() != 0});
                if (act_data_in_vld[r] && act_data_in_req[r]) begin
                    if (expq[r].size() == 0)
                        chk($sformatf("unexpected_beat[%0d]", r), act_data_in[r*32 +: 32], 32'hxxxx_xxxx);
                    else
                        chk($sformatf("data[%0d]", r), act_data_in[r*32 +: 32], expq[r].pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_data = '0; in_row = '0; in_vld = 1'b0;
        flush = 1'b0; act_data_in_req = '0;
        #12;
        chk("rst_vld",   {26'd0, act_data_in_vld}, 32'h0);
        chk("rst_empty", {26'd0, row_empty}, 32'h3f);
        chk("rst_err",   {31'd0, err_row}, 32'h0);
        chk("rst_rdy",   {31'd0, in_rdy}, 32'h1);
        @(negedge clk_l);
        rst_n = 1'b1;
        step();

        // Single beat to row 3
        drive(3, 32'h0001_0002, 1'b1);
        chk("single_vld",   {26'd0, act_data_in_vld}, 32'h08);
        chk("single_data",  act_data_in[3*32 +: 32], 32'h0001_0002);
        chk("single_empty", {31'd0, row_empty[3]}, 32'h0);
        act_data_in_req = 6'b001000;
        step();
        act_data_in_req = '0;
        chk("single_drained", {26'd0, act_data_in_vld}, 32'h0);

        // Fill row 0, backpressure only on row 0
        for (int i = 1; i <= 4; i++) drive(0, 32'(i), 1'b1);
        drive(0, 32'h5, 1'b0);
        drive(1, 32'haa, 1'b1);
        act_data_in_req = 6'b000011;
        for (int i = 0; i < 4; i++) step();
        act_data_in_req = '0;
        chk("fill_drained", {26'd0, act_data_in_vld}, 32'h0);

        // Full row 2 with simultaneous pop: push refused, slot free next cycle
        for (int i = 1; i <= 4; i++) drive(2, 32'h20 + 32'(i), 1'b1);
        act_data_in_req = 6'b000100;
        drive(2, 32'h25, 1'b0);
        act_data_in_req = '0;
        drive(2, 32'h26, 1'b1);
        drive(2, 32'h27, 1'b0);
        act_data_in_req = 6'b000100;
        for (int i = 0; i < 4; i++) step();
        act_data_in_req = '0;
        chk("full_drained", {26'd0, act_data_in_vld}, 32'h0);

        // Streaming through row 5
        act_data_in_req = 6'b100000;
        for (int i = 0; i < 20; i++) drive(5, 32'h500 + 32'(i), 1'b1);
        step();
        act_data_in_req = '0;
        chk("stream_drained", {26'd0, act_data_in_vld}, 32'h0);

        // Bad row then flush
        drive(7, 32'hdead, 1'b1);
        chk("bad_err", {31'd0, err_row}, 32'h1);
        chk("bad_vld", {26'd0, act_data_in_vld}, 32'h0);
        drive(0, 32'ha0, 1'b1);
        drive(0, 32'ha1, 1'b1);
        drive(1, 32'hb0, 1'b1);
        drive(1, 32'hb1, 1'b1);
        flush = 1'b1;
        @(negedge clk_l);
        chk("flush_rdy", {31'd0, in_rdy}, 32'h0);
        step();
        flush = 1'b0;
        clear_model();
        chk("flush_vld",   {26'd0, act_data_in_vld}, 32'h0);
        chk("flush_empty", {26'd0, row_empty}, 32'h3f);
        chk("flush_err",   {31'd0, err_row}, 32'h1);

        // Asynchronous reset with rows partially full
        drive(0, 32'hc0, 1'b1);
        drive(1, 32'hc1, 1'b1);
        drive(2, 32'hc2, 1'b1);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("arst_vld",   {26'd0, act_data_in_vld}, 32'h0);
        chk("arst_empty", {26'd0, row_empty}, 32'h3f);
        chk("arst_err",   {31'd0, err_row}, 32'h0);
        chk("arst_rdy",   {31'd0, in_rdy}, 32'h1);
        @(negedge clk_l);
        #1;
        rst_n = 1'b1;
        step();
        drive(4, 32'h4444, 1'b1);
        chk("post_rst_vld",  {26'd0, act_data_in_vld}, 32'h10);
        chk("post_rst_data", act_data_in[4*32 +: 32], 32'h4444);
        act_data_in_req = '1;
        step();
        act_data_in_req = '0;
        step();
        chk("end_vld", {26'd0, act_data_in_vld}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/act_dispatch.md
ACT_DISPATCH -- requirements
Module: act_dispatch

Interface
REQ-001 The block SHALL expose the following parameters:
- N_ROW, 6, number of superblock rows fed.
- WID_ACT, 16, activation element width; one beat is 2*WID_ACT bits.
- FIFO_DEPTH, 4, entries per row FIFO; power of two, at least 2.
- WID_ROW, $clog2(N_ROW), row-index width.

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk_l, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_data, in, 2*WID_ACT, incoming activation beat.
- in_row, in, WID_ROW, destination row index of in_data.
- in_vld, in, 1, in_data/in_row valid.
- in_rdy, out, 1, block accepts the beat this cycle.
- flush, in, 1, synchronous clear of all row FIFOs.
- act_data_in, out, 2*WID_ACT*N_ROW, per-row head beat; row r at bits [r*2*WID_ACT +: 2*WID_ACT].
- act_data_in_vld, out, N_ROW, row r head valid.
- act_data_in_req, in, N_ROW, row r superblock ready to take a beat.
- row_empty, out, N_ROW, row r FIFO empty.
- err_row, out, 1, sticky flag: a beat with in_row >= N_ROW was accepted.

Function
REQ-003 Input transfer SHALL occur when in_vld and in_rdy are both 1 on a clk_l edge.

REQ-004 Output transfer for row r SHALL occur when act_data_in_vld[r] and act_data_in_req[r] are both 1 on a clk_l edge.

REQ-005 The block SHALL contain one independent FIFO per row, FIFO_DEPTH entries deep, each with a count register of width $clog2(FIFO_DEPTH+1).

REQ-006 in_rdy SHALL be computed combinationally and SHALL NOT depend on in_vld:
- 0 when flush=1;
- else 1 when in_row >= N_ROW;
- else 1 when count[in_row] < FIFO_DEPTH;
- else 0.

REQ-007 An accepted beat with in_row < N_ROW SHALL be written at the write pointer of FIFO in_row; the pointer wraps modulo FIFO_DEPTH.

REQ-008 An accepted beat with in_row >= N_ROW SHALL be discarded and SHALL set err_row to 1; err_row stays 1 until reset.

REQ-009 act_data_in_vld[r] SHALL equal (count[r] != 0), and act_data_in slice r SHALL present the entry at the read pointer (first-word-fall-through).

REQ-010 An output transfer on row r SHALL advance read pointer r modulo FIFO_DEPTH.

REQ-011 Latency from an input transfer into an empty row FIFO to act_data_in_vld high on that row SHALL be exactly 1 cycle; there is no combinational bypass from in_data to act_data_in.

REQ-012 A simultaneous push and pop on the same row SHALL leave count unchanged and advance both pointers.

REQ-013 A full row SHALL keep in_rdy=0 for that row even when a pop occurs in the same cycle; the freed slot is usable from the next cycle.

REQ-014 Beats to a given row SHALL be delivered in acceptance order; rows are mutually independent, and backpressure on one row SHALL NOT block pushes to other rows.

REQ-015 act_data_in_req[r] SHALL be ignored while act_data_in_vld[r]=0, with no state change.

REQ-016 flush=1 SHALL clear all counts and pointers on that edge and has priority over a simultaneous pop. Pushes are already blocked during flush per REQ-006. err_row is unaffected by flush.

REQ-017 row_empty[r] SHALL equal (count[r] == 0).

REQ-018 FIFO storage contents SHALL need no reset; act_data_in is don't-care while act_data_in_vld[r]=0.

Reset
REQ-019 While rst_n=0, asynchronously:
- all counts and pointers SHALL be 0;
- act_data_in_vld SHALL be 0;
- row_empty SHALL be all ones;
- err_row SHALL be 0;
- in_rdy SHALL follow REQ-006 with empty FIFOs, i.e. it is 1 when flush=0.

REQ-020 Reset asserted mid-transfer SHALL drop all buffered beats. After rst_n deasserts, the first edge SHALL accept a transfer normally.

Verification
REQ-021 Single beat: push 0x0001_0002 to row 3 with all req=0 -> act_data_in_vld=6'b001000 one cycle later, slice 3 = 0x00010002, row_empty[3]=0.

REQ-022 Fill and backpressure: push 4 beats (values 1..4) to row 0 with req[0]=0 -> in_rdy=0 while in_row=0, in_rdy=1 while in_row=1. Then raise req[0] -> row 0 outputs 1,2,3,4 on consecutive cycles, then vld[0]=0.

REQ-023 Full with simultaneous pop: row 2 full, req[2]=1, in_row=2, in_vld=1 -> no push that cycle, count drops to 3. Push accepted on the next cycle, count back to 4.

REQ-024 Streaming: push every cycle to row 5 with req[5]=1 held for 20 cycles -> in_rdy constantly 1, output sequence equals input sequence delayed 1 cycle, count never exceeds 1.

REQ-025 Bad row and flush: push with in_row=7 -> in_rdy=1, err_row=1, no vld change. Then load rows 0 and 1 with 2 beats each and assert flush one cycle -> all vld=0 and row_empty=6'h3F next cycle, err_row still 1.

REQ-026 Reset mid-stream: assert rst_n=0 asynchronously between edges with rows partially full -> vld=0 immediately. After release, a push to row 4 appears on the output after 1 cycle.
